// File: rtl/keypad_scan_module_pkg.sv
// rtl/keypad_scan_module_pkg.sv - shared encodings for the keypad scanner
package keypad_scan_module_pkg;

    typedef enum logic [1:0] {
        KS_IDLE     = 2'd0,
        KS_DEBOUNCE = 2'd1,
        KS_PRESSED  = 2'd2,
        KS_RELEASE  = 2'd3
    } ks_state_t;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } fr_class_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Active-low one-hot drive for the selected row.
    function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
        return ~(4'b0001 << row_idx);
    endfunction

endpackage

// File: rtl/keypad_scan_module_key_frame_decoder.sv
// rtl/keypad_scan_module_key_frame_decoder.sv - classifies a 16-key frame as none/single/multi
import keypad_scan_module_pkg::*;

module key_frame_decoder (
    input  logic [15:0] frame,
    output fr_class_t   cls,
    output logic [3:0]  idx
);

    logic [1:0] w_seen;

    // Count set bits up to two and remember the first set position.
    always_comb begin
        w_seen = 2'd0;
        idx    = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                if (w_seen == 2'd0) begin
                    idx    = 4'(i);
                    w_seen = 2'd1;
                end else begin
                    w_seen = 2'd2;
                end
            end
        end
        case (w_seen)
            2'd0:    cls = FR_NONE;
            2'd1:    cls = FR_SINGLE;
            default: cls = FR_MULTI;
        endcase
    end

endmodule

// File: rtl/keypad_scan_module.sv
// rtl/keypad_scan_module.sv - 4x4 matrix keypad scanner with frame-level debounce
import keypad_scan_module_pkg::*;

module keypad_scan_module #(
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clk_500Hz,
    input  logic       rst_n,
    input  logic       en,
    output logic [3:0] row_out,
    input  logic [3:0] col_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

    logic [1:0]  r_scan_cnt;
    logic [15:0] r_frame;
    ks_state_t   r_state;
    logic [3:0]  r_deb_cnt;
    logic [3:0]  r_cand;
    logic [3:0]  r_key_code;
    logic        r_key_valid;
    logic        r_key_held;

    logic [15:0] w_frame_full;
    logic        w_frame_end;
    fr_class_t   w_cls;
    logic [3:0]  w_idx;
    logic [3:0]  w_deb_inc;

    ks_state_t   w_state_nx;
    logic [3:0]  w_deb_nx;
    logic [3:0]  w_cand_nx;
    logic [3:0]  w_code_nx;
    logic        w_valid_nx;
    logic        w_held_nx;

    assign row_out   = en ? row_drive(r_scan_cnt) : ROW_IDLE;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

    // Row counter and frame capture; disabling clears the frame so a restart never sees stale rows.
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= 2'd0;
            r_frame    <= 16'h0000;
        end else if (!en) begin
            r_scan_cnt <= 2'd0;
            r_frame    <= 16'h0000;
        end else begin
            r_scan_cnt                          <= r_scan_cnt + 2'd1;
            r_frame[{r_scan_cnt, 2'b00} +: 4]   <= ~col_in;
        end
    end

    // The completed frame includes the row sample being taken on this same edge.
    always_comb begin
        w_frame_full                               = r_frame;
        w_frame_full[{r_scan_cnt, 2'b00} +: 4]     = ~col_in;
    end

    assign w_frame_end = en && (r_scan_cnt == 2'd3);
    assign w_deb_inc   = (r_deb_cnt == 4'hF) ? 4'hF : r_deb_cnt + 4'd1;

    key_frame_decoder u_decoder (
        .frame (w_frame_full),
        .cls   (w_cls),
        .idx   (w_idx)
    );

    // FSM state and output registers.
    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= KS_IDLE;
            r_deb_cnt   <= 4'd0;
            r_cand      <= 4'h0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_deb_cnt   <= w_deb_nx;
            r_cand      <= w_cand_nx;
            r_key_code  <= w_code_nx;
            r_key_valid <= w_valid_nx;
            r_key_held  <= w_held_nx;
        end
    end

    // Debounce decisions, taken only at frame ends; a MULTI frame blocks acceptance but also blocks release.
    always_comb begin
        w_state_nx = r_state;
        w_deb_nx   = r_deb_cnt;
        w_cand_nx  = r_cand;
        w_code_nx  = r_key_code;
        w_valid_nx = 1'b0;
        w_held_nx  = r_key_held;
        if (!en) begin
            w_state_nx = KS_IDLE;
            w_deb_nx   = 4'd0;
            w_held_nx  = 1'b0;
        end else if (w_frame_end) begin
            case (r_state)
                KS_IDLE: begin
                    if (w_cls == FR_SINGLE) begin
                        if (DEB_N <= 4'd1) begin
                            w_code_nx  = w_idx;
                            w_valid_nx = 1'b1;
                            w_held_nx  = 1'b1;
                            w_deb_nx   = 4'd0;
                            w_state_nx = KS_PRESSED;
                        end else begin
                            w_cand_nx  = w_idx;
                            w_deb_nx   = 4'd1;
                            w_state_nx = KS_DEBOUNCE;
                        end
                    end
                end
                KS_DEBOUNCE: begin
                    if (w_cls == FR_SINGLE && w_idx == r_cand) begin
                        if (w_deb_inc >= DEB_N) begin
                            w_code_nx  = r_cand;
                            w_valid_nx = 1'b1;
                            w_held_nx  = 1'b1;
                            w_deb_nx   = 4'd0;
                            w_state_nx = KS_PRESSED;
                        end else begin
                            w_deb_nx = w_deb_inc;
                        end
                    end else begin
                        w_deb_nx   = 4'd0;
                        w_state_nx = KS_IDLE;
                    end
                end
                KS_PRESSED: begin
                    if (w_cls == FR_NONE) begin
                        if (DEB_N <= 4'd1) begin
                            w_held_nx  = 1'b0;
                            w_deb_nx   = 4'd0;
                            w_state_nx = KS_IDLE;
                        end else begin
                            w_deb_nx   = 4'd1;
                            w_state_nx = KS_RELEASE;
                        end
                    end
                end
                KS_RELEASE: begin
                    if (w_cls == FR_NONE) begin
                        if (w_deb_inc >= DEB_N) begin
                            w_held_nx  = 1'b0;
                            w_deb_nx   = 4'd0;
                            w_state_nx = KS_IDLE;
                        end else begin
                            w_deb_nx = w_deb_inc;
                        end
                    end else begin
                        w_deb_nx   = 4'd0;
                        w_state_nx = KS_PRESSED;
                    end
                end
                default: begin
                    w_deb_nx   = 4'd0;
                    w_state_nx = KS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_module.sv
// tb/tb_keypad_scan_module.sv - randomized bench for keypad_scan_module against a frame-level model
module tb_keypad_scan_module;

    localparam int N = 3;

    logic        clk_500Hz = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en        = 1'b0;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: which row is being sampled, the keys seen this frame,
    // and how many consecutive qualifying frames have been observed.
    int          m_row;
    logic [15:0] m_frame;
    bit          m_held;
    bit          m_valid;
    logic [3:0]  m_code;
    int          m_run_key;
    int          m_run_len;
    int          m_empty;

    always #5 clk_500Hz = ~clk_500Hz;

    // Physical keypad: a pressed key connects its row to its column.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) col_in = col_in & ~keys[4*r +: 4];
        end
    end

    keypad_scan_module #(.DEBOUNCE_SCANS(N)) dut (
        .clk_500Hz (clk_500Hz),
        .rst_n     (rst_n),
        .en        (en),
        .row_out   (row_out),
        .col_in    (col_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_row     = 0;
        m_frame   = 16'h0;
        m_held    = 0;
        m_valid   = 0;
        m_run_len = 0;
        m_empty   = 0;
    endtask

    task automatic model_edge();
        int pop;
        int k;
        if (!rst_n) begin
            model_clear();
            m_code    = 4'h0;
            m_run_key = 0;
        end else if (!en) begin
            model_clear();
        end else begin
            m_valid = 0;
            m_frame[4*m_row +: 4] = keys[4*m_row +: 4];
            if (m_row == 3) begin
                pop = $countones(m_frame);
                k = 0;
                for (int i = 15; i >= 0; i--) if (m_frame[i]) k = i;
                if (!m_held) begin
                    if (pop == 1) begin
                        if (m_run_len > 0 && k == m_run_key) m_run_len++;
                        else if (m_run_len > 0)              m_run_len = 0;
                        else begin
                            m_run_key = k;
                            m_run_len = 1;
                        end
                    end else begin
                        m_run_len = 0;
                    end
                    if (m_run_len >= N) begin
                        m_held    = 1;
                        m_valid   = 1;
                        m_code    = 4'(k);
                        m_run_len = 0;
                        m_empty   = 0;
                    end
                end else begin
                    if (pop == 0) m_empty++;
                    else          m_empty = 0;
                    if (m_empty >= N) begin
                        m_held    = 0;
                        m_empty   = 0;
                        m_run_len = 0;
                    end
                end
            end
            m_row = (m_row + 1) % 4;
        end
    endtask

    task automatic cycles(input int n);
        logic [3:0] exp_row;
        for (int c = 0; c < n; c++) begin
            @(posedge clk_500Hz);
            model_edge();
            @(negedge clk_500Hz);
            exp_row = en ? ~(4'b0001 << m_row) : 4'b1111;
            check_val("row_out",   {12'h0, row_out},   {12'h0, exp_row});
            check_val("key_code",  {12'h0, key_code},  {12'h0, m_code});
            check_val("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
            check_val("key_held",  {15'h0, key_held},  {15'h0, m_held});
        end
    endtask

    initial begin
        int sel;
        int b0;
        int b1;
        model_clear();
        m_code    = 4'h0;
        m_run_key = 0;

        // Reset with scanning enabled and no keys.
        en = 1'b1;
        #2;
        check_val("reset_row", {12'h0, row_out}, 16'h000E);
        cycles(3);
        rst_n = 1'b1;
        cycles(8);

        // Key 9 (row 2, col 1) steady for five frames.
        keys = 16'h0001 << 9;
        cycles(20);
        check_val("code9_held", {12'h0, key_code}, 16'h0009);

        // Release for four frames; code is retained.
        keys = 16'h0000;
        cycles(16);
        check_val("code9_kept", {12'h0, key_code}, 16'h0009);

        // Bounce on key 5: present, absent, present, then stable.
        keys = 16'h0020; cycles(4);
        keys = 16'h0000; cycles(4);
        keys = 16'h0020; cycles(16);
        keys = 16'h0000; cycles(16);

        // Keys 0 and 15 together, then only key 0.
        keys = 16'h8001; cycles(16);
        keys = 16'h0001; cycles(16);

        // Drop enable while pressed, then re-enable with the key still held.
        en = 1'b0; cycles(3);
        en = 1'b1; cycles(16);
        keys = 16'h0000; cycles(16);

        // Randomized key activity, not aligned to frame boundaries.
        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 9);
            b0  = $urandom_range(0, 15);
            b1  = $urandom_range(0, 15);
            if (sel <= 3) begin
                keys = 16'h0000;
            end else if (sel <= 7) begin
                keys = 16'h0001 << b0;
            end else if (sel == 8) begin
                keys = (16'h0001 << b0) | (16'h0001 << b1);
            end else begin
                en = 1'b0;
                cycles($urandom_range(1, 6));
                en = 1'b1;
            end
            cycles($urandom_range(1, 24));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
